// File: rtl/data_mem_responder.sv
// Wait-state data memory responder: accepts one load/store over valid/ready and answers
// after LATENCY cycles. Storage is little-endian, byte-addressed, 64-bit doublewords.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o
);
  localparam int IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t stateReg, stateNext;

  logic [3:0]  cntReg;
  logic        weReg;
  logic        unsReg;
  logic [63:0] addrReg;
  logic [63:0] wdataReg;
  logic [1:0]  sizeReg;
  logic [63:0] rawReg;
  logic [63:0] rdataReg;
  logic        errReg;
  logic [63:0] mem [DEPTH];

  logic            accept;
  logic            access;
  logic            misaligned;
  logic            outOfRange;
  logic            fault;
  logic [2:0]      offset;
  logic [2:0]      alignMask;
  logic [7:0]      laneMask;
  logic [7:0]      byteEn;
  logic [63:0]     wdataShift;
  logic [63:0]     loadShift;
  logic [63:0]     loadData;
  logic [IdxW-1:0] rdIdx;
  logic [IdxW-1:0] wrIdx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (stateReg)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) stateNext = WAIT;
      end
      WAIT: begin
        if (cntReg == 4'd0) stateNext = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign accept = (stateReg == IDLE) && req_valid_i;
  assign access = (stateReg == WAIT) && (cntReg == 4'd0);
  assign offset = addrReg[2:0];
  assign rdIdx  = req_addr_i[IdxW+2:3];
  assign wrIdx  = addrReg[IdxW+2:3];

  always_comb begin
    alignMask = 3'b000;
    laneMask  = 8'h01;
    case (sizeReg)
      2'd0:    begin alignMask = 3'b000; laneMask = 8'h01; end
      2'd1:    begin alignMask = 3'b001; laneMask = 8'h03; end
      2'd2:    begin alignMask = 3'b011; laneMask = 8'h0F; end
      default: begin alignMask = 3'b111; laneMask = 8'hFF; end
    endcase
  end

  // Full upper address is compared so high addresses fault instead of aliasing.
  assign misaligned = |(offset & alignMask);
  assign outOfRange = addrReg[63:3] >= 61'(DEPTH);
  assign fault      = misaligned || outOfRange;
  assign byteEn     = laneMask << offset;
  assign wdataShift = wdataReg << {offset, 3'b000};
  assign loadShift  = rawReg >> {offset, 3'b000};

  always_comb begin
    loadData = loadShift;
    case (sizeReg)
      2'd0: loadData = unsReg ? {56'd0, loadShift[7:0]}  : {{56{loadShift[7]}}, loadShift[7:0]};
      2'd1: loadData = unsReg ? {48'd0, loadShift[15:0]} : {{48{loadShift[15]}}, loadShift[15:0]};
      2'd2: loadData = unsReg ? {32'd0, loadShift[31:0]} : {{32{loadShift[31]}}, loadShift[31:0]};
      default: loadData = loadShift;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cntReg   <= 4'd0;
      rdataReg <= 64'd0;
      errReg   <= 1'b0;
    end else begin
      if (accept) begin
        cntReg <= 4'(LATENCY);
      end else if ((stateReg == WAIT) && (cntReg != 4'd0)) begin
        cntReg <= cntReg - 4'd1;
      end
      if (access) begin
        errReg   <= fault;
        rdataReg <= (fault || weReg) ? 64'd0 : loadData;
      end
    end
  end

  // Request capture; the doubleword is read here so the array sees a registered read.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      weReg    <= req_we_i;
      addrReg  <= req_addr_i;
      wdataReg <= req_wdata_i;
      sizeReg  <= req_size_i;
      unsReg   <= req_unsigned_i;
      rawReg   <= mem[rdIdx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && access && weReg && !fault) begin
      for (int b = 0; b < 8; b++) begin
        if (byteEn[b]) mem[wrIdx][8*b +: 8] <= wdataShift[8*b +: 8];
      end
    end
  end

  assign rsp_rdata_o = rdataReg;
  assign rsp_err_o   = errReg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: byte-array reference model, per-cycle monitor,
// directed literal cases, plus a LATENCY=0 instance for back-to-back throughput.
module tb_data_mem_responder;
  localparam int LAT = 2;
  localparam int DEP = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0, reqWe = 1'b0, reqUns = 1'b0, rspReady = 1'b0;
  logic [63:0] reqAddr = '0, reqWdata = '0;
  logic [1:0]  reqSize = '0;
  logic        reqReady, rspValid, rspErr;
  logic [63:0] rspRdata;

  logic        reqValid1 = 1'b0, reqWe1 = 1'b0, reqUns1 = 1'b0, rspReady1 = 1'b0;
  logic [63:0] reqAddr1 = '0, reqWdata1 = '0;
  logic [1:0]  reqSize1 = '0;
  logic        reqReady1, rspValid1, rspErr1;
  logic [63:0] rspRdata1;

  int nVec = 0;
  int nMis = 0;
  logic [63:0] cyc = '0;
  logic [7:0]  modelMem [DEP*8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 64'd1;

  data_mem_responder #(.DEPTH(DEP), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(reqValid), .req_ready_o(reqReady),
    .req_we_i(reqWe), .req_addr_i(reqAddr), .req_wdata_i(reqWdata), .req_size_i(reqSize),
    .req_unsigned_i(reqUns), .rsp_valid_o(rspValid), .rsp_ready_i(rspReady),
    .rsp_rdata_o(rspRdata), .rsp_err_o(rspErr)
  );

  data_mem_responder #(.DEPTH(DEP), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(reqValid1), .req_ready_o(reqReady1),
    .req_we_i(reqWe1), .req_addr_i(reqAddr1), .req_wdata_i(reqWdata1), .req_size_i(reqSize1),
    .req_unsigned_i(reqUns1), .rsp_valid_o(rspValid1), .rsp_ready_i(rspReady1),
    .rsp_rdata_o(rspRdata1), .rsp_err_o(rspErr1)
  );

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    nVec++;
    nMis++;
    $display("FAIL %s: timed out at t=%0t", name, $time);
  endtask

  // Reference: fault if misaligned or past the end; otherwise move bytes and extend.
  task automatic modelAccess(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [1:0] size, input logic uns,
                             output logic [63:0] rd, output logic err);
    int nb;
    nb  = 1 << size;
    rd  = '0;
    err = ((addr % 64'(nb)) != 64'd0) || (addr >= 64'(DEP*8));
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        if (we) modelMem[int'(addr) + i] = wdata[8*i +: 8];
        else    rd[8*i +: 8] = modelMem[int'(addr) + i];
      end
      if (!we && nb < 8 && !uns && rd[8*nb-1]) rd = rd | ~((64'd1 << (8*nb)) - 64'd1);
    end
  endtask

  // Monitor: compares DUT against the model on every negedge.
  bit armed = 0, rstPend = 0, accPend = 0, hsPend = 0, inFlight = 0, respSeen = 0;
  logic        capWe, capUns, expErr;
  logic [63:0] capAddr, capWdata, expRd, accCyc;
  logic [1:0]  capSize;

  always @(negedge clk) begin
    if (rstPend) begin
      check64("rst_ready", reqReady, 64'd1);
      check64("rst_valid", rspValid, 64'd0);
      check64("rst_rdata", rspRdata, 64'd0);
      check64("rst_err", rspErr, 64'd0);
      inFlight = 0; respSeen = 0; accPend = 0; hsPend = 0; rstPend = 0; armed = 1;
    end else if (armed) begin
      if (hsPend) begin inFlight = 0; respSeen = 0; hsPend = 0; end
      if (accPend) begin inFlight = 1; respSeen = 0; accCyc = cyc; accPend = 0; end
      check64("ready_valid_excl", reqReady & rspValid, 64'd0);
      if (!inFlight) begin
        check64("idle_ready", reqReady, 64'd1);
        check64("idle_valid", rspValid, 64'd0);
      end else begin
        check64("busy_ready", reqReady, 64'd0);
        if (rspValid) begin
          if (!respSeen) begin
            check64("rsp_latency", cyc - accCyc, 64'(LAT + 1));
            modelAccess(capWe, capAddr, capWdata, capSize, capUns, expRd, expErr);
            respSeen = 1;
          end
          check64("rsp_rdata", rspRdata, expRd);
          check64("rsp_err", rspErr, expErr);
        end else if (respSeen) begin
          check64("rsp_valid_hold", rspValid, 64'd1);
        end else if (cyc - accCyc >= 64'(LAT + 1)) begin
          check64("rsp_valid_late", rspValid, 64'd1);
        end
      end
    end
    if (rst) begin
      rstPend = 1;
    end else if (armed) begin
      if (reqValid && reqReady) begin
        accPend = 1; capWe = reqWe; capAddr = reqAddr; capWdata = reqWdata;
        capSize = reqSize; capUns = reqUns;
      end
      if (rspValid && rspReady) hsPend = 1;
    end
  end

  task automatic doTxn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [1:0] size, input logic uns, input int bp,
                       output logic [63:0] rd, output logic err);
    bit ok;
    rd = '0;
    err = 1'b0;
    @(posedge clk); #1;
    reqValid = 1'b1; reqWe = we; reqAddr = addr; reqWdata = wdata; reqSize = size; reqUns = uns;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (reqReady) begin ok = 1; break; end
    end
    if (!ok) begin timeoutFail("accept"); reqValid = 1'b0; return; end
    @(posedge clk); #1;
    reqValid = 1'b0; reqWe = 1'($urandom); reqAddr = {$urandom, $urandom};
    reqWdata = {$urandom, $urandom}; reqSize = 2'($urandom); reqUns = 1'($urandom);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rspValid) begin ok = 1; break; end
    end
    if (!ok) begin timeoutFail("response"); return; end
    rd = rspRdata;
    err = rspErr;
    repeat (bp) @(posedge clk);
    @(posedge clk); #1 rspReady = 1'b1;
    @(posedge clk); #1 rspReady = 1'b0;
  endtask

  task automatic setReq1(input int idx, input logic [63:0] pv);
    reqWe1 = (idx < 4);
    reqAddr1 = 64'((idx % 4) * 8);
    reqWdata1 = pv;
    reqSize1 = 2'd3;
    reqUns1 = 1'b0;
  endtask

  initial begin
    logic [63:0] rd, addr, expv;
    logic        err, acc, ok;
    logic [1:0]  size;
    logic [63:0] pat [4];
    int idx, k, lastV;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < DEP; i++) doTxn(1'b1, 64'(i * 8), 64'd0, 2'd3, 1'b0, 0, rd, err);

    doTxn(1'b1, 64'h10, 64'h1122334455667788, 2'd3, 1'b0, 0, rd, err);
    check64("st_dword_rdata", rd, 64'd0);
    check64("st_dword_err", err, 64'd0);
    doTxn(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 0, rd, err);
    check64("ld_dword", rd, 64'h1122334455667788);

    doTxn(1'b1, 64'h13, 64'hFFFF_FFFF_FFFF_FFF0, 2'd0, 1'b0, 1, rd, err);
    doTxn(1'b0, 64'h13, 64'd0, 2'd0, 1'b0, 0, rd, err);
    check64("ld_byte_signed", rd, 64'hFFFFFFFFFFFFFFF0);
    doTxn(1'b0, 64'h13, 64'd0, 2'd0, 1'b1, 2, rd, err);
    check64("ld_byte_unsigned", rd, 64'h00000000000000F0);
    doTxn(1'b0, 64'h10, 64'd0, 2'd3, 1'b1, 0, rd, err);
    check64("ld_dword_merged", rd, 64'h11223344F0667788);

    doTxn(1'b0, 64'h11, 64'd0, 2'd1, 1'b0, 0, rd, err);
    check64("misaligned_err", err, 64'd1);
    check64("misaligned_rdata", rd, 64'd0);
    doTxn(1'b1, 64'(DEP * 8), 64'hDEADBEEF, 2'd2, 1'b0, 0, rd, err);
    check64("range_err", err, 64'd1);
    doTxn(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 0, rd, err);
    check64("ld_after_faults", rd, 64'h11223344F0667788);

    // Backpressure with a request still offered
    @(posedge clk); #1;
    reqValid = 1'b1; reqWe = 1'b0; reqAddr = 64'h10; reqSize = 2'd3; reqUns = 1'b0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = reqReady; end
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = rspValid; end
    if (!ok) timeoutFail("bp_response");
    for (int i = 0; i < 5; i++) begin
      check64("bp_valid", rspValid, 64'd1);
      check64("bp_ready", reqReady, 64'd0);
      check64("bp_rdata", rspRdata, 64'h11223344F0667788);
      @(negedge clk);
    end
    @(posedge clk); #1 rspReady = 1'b1;
    @(posedge clk); #1 rspReady = 1'b0; reqValid = 1'b0;
    @(negedge clk);
    check64("bp_release_ready", reqReady, 64'd1);
    check64("bp_release_valid", rspValid, 64'd0);

    // Reset while a store waits
    @(posedge clk); #1;
    reqValid = 1'b1; reqWe = 1'b1; reqAddr = 64'h20; reqWdata = 64'hAA; reqSize = 2'd0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = reqReady; end
    @(posedge clk); #1 reqValid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check64("midrst_valid", rspValid, 64'd0);
    check64("midrst_ready", reqReady, 64'd1);
    doTxn(1'b0, 64'h20, 64'd0, 2'd0, 1'b1, 0, rd, err);
    check64("midrst_no_commit", rd, 64'd0);

    for (int t = 0; t < 300; t++) begin
      size = 2'($urandom_range(0, 3));
      addr = 64'($urandom_range(0, DEP + 1)) * 64'd8 + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << size) - 64'd1);
      if ($urandom_range(0, 15) == 0) addr[$urandom_range(40, 63)] = 1'b1;
      doTxn(1'($urandom), addr, {$urandom, $urandom}, size, 1'($urandom),
            int'($urandom_range(0, 3)), rd, err);
    end

    // LATENCY=0 instance: back-to-back requests, one response every 3 cycles
    for (int i = 0; i < 4; i++) pat[i] = {$urandom, $urandom};
    @(posedge clk); #1;
    idx = 0; k = 0; lastV = 0;
    setReq1(0, pat[0]);
    reqValid1 = 1'b1; rspReady1 = 1'b1;
    for (int c = 0; c < 60 && k < 8; c++) begin
      @(negedge clk);
      check64("l0_excl", reqReady1 & rspValid1, 64'd0);
      if (rspValid1) begin
        expv = (k < 4) ? 64'd0 : pat[k-4];
        check64("l0_rdata", rspRdata1, expv);
        check64("l0_err", rspErr1, 64'd0);
        check64("l0_spacing", 64'(c - lastV), (k == 0) ? 64'd2 : 64'd3);
        lastV = c;
        k++;
      end
      acc = reqReady1 && reqValid1;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 8) setReq1(idx, (idx < 4) ? pat[idx] : 64'd0);
        else reqValid1 = 1'b0;
      end
    end
    if (k < 8) timeoutFail("l0_responses");
    reqValid1 = 1'b0;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
